// File: rtl/load_unit_pkg.sv
// load_unit_pkg: load op encodings and the alignment helper shared by the load path.
package load_unit_pkg;

   localparam logic [2:0] DE_WORD = 3'b000;
   localparam logic [2:0] DE_BU   = 3'b001;
   localparam logic [2:0] DE_B    = 3'b010;
   localparam logic [2:0] DE_HU   = 3'b011;
   localparam logic [2:0] DE_H    = 3'b100;

   // True when the access would straddle its natural boundary; bytes never fault.
   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
      case (op)
         DE_WORD:     return addr_lo != 2'b00;
         DE_HU, DE_H: return addr_lo[0];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_unit_ext.sv
// load_ext: selects the addressed byte/halfword lane of a read word and extends it.
module load_ext
   import load_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  op,
   output logic [31:0] data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      case (addr_lo)
         2'd0:    lane_byte = rdata[7:0];
         2'd1:    lane_byte = rdata[15:8];
         2'd2:    lane_byte = rdata[23:16];
         default: lane_byte = rdata[31:24];
      endcase
      lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Undefined op codes still perform the bus access but return zero.
   always_comb begin
      case (op)
         DE_WORD: data = rdata;
         DE_BU:   data = {24'h0, lane_byte};
         DE_B:    data = {{24{lane_byte[7]}}, lane_byte};
         DE_HU:   data = {16'h0, lane_half};
         DE_H:    data = {{16{lane_half[15]}}, lane_half};
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/load_unit.sv
// load_unit: M-stage load engine with a valid/ready read bus, pipeline stall and flush draining.
// Optional misaligned-load trap: define LOAD_ALIGN_CHECK_EN.
module load_unit
   import load_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_op,
   output logic        req_ready,
   input  logic        flush,
   output logic        m_rd_valid,
   output logic [31:0] m_rd_addr,
   input  logic        m_rd_ready,
   input  logic        m_rd_rvalid,
   input  logic [31:0] m_rd_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        stall,
   output logic        exc_adel
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP,
      S_DRAIN
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [2:0]  op_q;
   logic [31:0] rsp_data_q;
   logic [31:0] ext_data;
   logic        accept;
   logic        capture;
   logic        fault;

   load_ext u_ext (
      .rdata   (m_rd_rdata),
      .addr_lo (addr_q[1:0]),
      .op      (op_q),
      .data    (ext_data)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      req_ready  = 1'b0;
      m_rd_valid = 1'b0;
      rsp_valid  = 1'b0;
      stall      = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      fault      = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !flush) begin
               accept = 1'b1;
               stall  = 1'b1;
`ifdef LOAD_ALIGN_CHECK_EN
               fault  = is_misaligned(req_op, req_addr[1:0]);
`endif
               state_d = fault ? S_RESP : S_ADDR;
            end
         end
         S_ADDR: begin
            m_rd_valid = 1'b1;
            stall      = 1'b1;
            // Once the bus has accepted the request the read data must still be absorbed.
            if (m_rd_ready) begin
               state_d = flush ? S_DRAIN : S_DATA;
            end else if (flush) begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            stall = 1'b1;
            if (m_rd_rvalid) begin
               capture = !flush;
               state_d = flush ? S_IDLE : S_RESP;
            end else if (flush) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            stall = 1'b1;
            if (m_rd_rvalid) begin
               state_d = S_IDLE;
            end
         end
         S_RESP: begin
            rsp_valid = !flush;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so each register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'h0;
         op_q       <= DE_WORD;
         rsp_data_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= req_addr;
            op_q   <= req_op;
         end
         if (capture) begin
            rsp_data_q <= ext_data;
         end else if (accept && fault) begin
            rsp_data_q <= 32'h0;
         end
      end
   end

`ifdef LOAD_ALIGN_CHECK_EN
   logic adel_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         adel_q <= 1'b0;
      end else if (accept) begin
         adel_q <= fault;
      end
   end

   assign exc_adel = rsp_valid && adel_q;
`else
   assign exc_adel = 1'b0;
`endif

   assign m_rd_addr = {addr_q[31:2], 2'b00};
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: randomized scoreboard bench for load_unit against a behavioural load model.
module tb_load_unit;

   localparam int K_NORMAL   = 0;
   localparam int K_WITHDRAW = 1;
   localparam int K_ADDR_HS  = 2;
   localparam int K_DATA     = 3;
   localparam int K_RVALID   = 4;
   localparam int K_RESP     = 5;

   typedef struct packed {
      logic [31:0] data;
      logic        exc;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [2:0]  req_op = 3'h0;
   logic        req_ready;
   logic        flush = 1'b0;
   logic        m_rd_valid;
   logic [31:0] m_rd_addr;
   logic        m_rd_ready = 1'b0;
   logic        m_rd_rvalid = 1'b0;
   logic [31:0] m_rd_rdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        stall;
   logic        exc_adel;

   int          n_vec = 0;
   int          n_bad = 0;
   rsp_t        exp_q[$];
   logic        bus_expected = 1'b0;
   logic [31:0] exp_bus_addr = 32'h0;
   logic [31:0] hold_data = 32'h0;

   always #5 clk = ~clk;

   load_unit dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_op      (req_op),
      .req_ready   (req_ready),
      .flush       (flush),
      .m_rd_valid  (m_rd_valid),
      .m_rd_addr   (m_rd_addr),
      .m_rd_ready  (m_rd_ready),
      .m_rd_rvalid (m_rd_rvalid),
      .m_rd_rdata  (m_rd_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .stall       (stall),
      .exc_adel    (exc_adel)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: pick the lane by arithmetic shift, then extend by value range.
   function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] op,
                                            input logic [31:0] rdata);
      logic [31:0] b;
      logic [31:0] h;
      b = (rdata >> (8 * addr[1:0])) & 32'hFF;
      h = (rdata >> (16 * addr[1])) & 32'hFFFF;
      case (op)
         3'd0:    return rdata;
         3'd1:    return b;
         3'd2:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd3:    return h;
         3'd4:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_fault(input logic [31:0] addr, input logic [2:0] op);
      bit enabled = 1'b0;
`ifdef LOAD_ALIGN_CHECK_EN
      enabled = 1'b1;
`endif
      return enabled && ((op == 3'd0 && (addr % 4) != 0) ||
                         ((op == 3'd3 || op == 3'd4) && (addr % 2) != 0));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response pops the scoreboard; bus requests must match the open load.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin
            check_bit("stall_in_resp", stall, 1'b0);
            if (exp_q.size() == 0) begin
               check_bit("rsp_valid_unexpected", rsp_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", rsp_data, e.data);
               check_bit("exc_adel", exc_adel, e.exc);
            end
         end else if (exc_adel) begin
            check_bit("exc_adel_without_rsp", exc_adel, 1'b0);
         end
         if (m_rd_valid) begin
            check_bit("m_rd_valid_expected", m_rd_valid, bus_expected);
            check("m_rd_addr", m_rd_addr, exp_bus_addr);
         end
      end
   end

   task automatic idle_cycle(input bit stray, input bit req_flush);
      req_valid   = req_flush;
      req_addr    = $urandom;
      req_op      = 3'($urandom_range(0, 7));
      flush       = req_flush;
      m_rd_rvalid = stray;
      m_rd_rdata  = $urandom;
      @(negedge clk);
      check_bit("stall_idle", stall, 1'b0);
      check_bit("req_ready_idle", req_ready, 1'b1);
      check("rsp_data_hold", rsp_data, hold_data);
      tick();
      req_valid   = 1'b0;
      flush       = 1'b0;
      m_rd_rvalid = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] rdata,
                          input int rw, input int vw, input int kind);
      logic [31:0] exp_d;
      bit          flt;
      bit          draining;
      exp_d = ref_load(addr, op, rdata);
      flt   = ref_fault(addr, op);

      req_valid = 1'b1;
      req_addr  = addr;
      req_op    = op;
      flush     = 1'b0;
      @(negedge clk);
      check_bit("req_ready_accept", req_ready, 1'b1);
      check_bit("stall_on_req", stall, 1'b1);
      check("rsp_data_hold", rsp_data, hold_data);
      tick();
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_op    = 3'($urandom_range(0, 7));

      if (flt) begin
         if (kind == K_RESP) flush = 1'b1;
         else exp_q.push_back('{data: 32'h0, exc: 1'b1});
         hold_data = 32'h0;
         @(negedge clk);
         check_bit("rsp_valid_adel", rsp_valid, kind != K_RESP);
         check_bit("stall_adel", stall, 1'b0);
         tick();
         flush = 1'b0;
         return;
      end

      bus_expected = 1'b1;
      exp_bus_addr = {addr[31:2], 2'b00};
      for (int i = 0; i < rw; i++) begin
         m_rd_ready = 1'b0;
         flush      = (kind == K_WITHDRAW) && (i == rw - 1);
         @(negedge clk);
         check_bit("m_rd_valid_addr", m_rd_valid, 1'b1);
         check_bit("stall_addr", stall, 1'b1);
         tick();
         if (flush) begin
            flush        = 1'b0;
            bus_expected = 1'b0;
            @(negedge clk);
            check_bit("m_rd_valid_withdrawn", m_rd_valid, 1'b0);
            check_bit("stall_withdrawn", stall, 1'b0);
            check_bit("req_ready_withdrawn", req_ready, 1'b1);
            tick();
            return;
         end
      end

      m_rd_ready = 1'b1;
      flush      = (kind == K_ADDR_HS);
      @(negedge clk);
      check_bit("m_rd_valid_hs", m_rd_valid, 1'b1);
      tick();
      m_rd_ready   = 1'b0;
      flush        = 1'b0;
      bus_expected = 1'b0;

      for (int i = 0; i < vw; i++) begin
         draining    = (kind == K_ADDR_HS) || (kind == K_DATA && i > 0);
         m_rd_rvalid = 1'b0;
         m_rd_rdata  = $urandom;
         flush       = ((kind == K_DATA) && (i == 0)) || (draining && $urandom_range(0, 1) == 1);
         @(negedge clk);
         check_bit("stall_data_wait", stall, 1'b1);
         tick();
         flush = 1'b0;
      end

      draining    = (kind == K_ADDR_HS) || (kind == K_DATA);
      m_rd_rvalid = 1'b1;
      m_rd_rdata  = rdata;
      flush       = (kind == K_RVALID) || (draining && $urandom_range(0, 1) == 1);
      @(negedge clk);
      check_bit("stall_rvalid", stall, 1'b1);
      tick();
      m_rd_rvalid = 1'b0;
      m_rd_rdata  = $urandom;
      flush       = 1'b0;

      if (kind == K_NORMAL || kind == K_RESP) begin
         if (kind == K_NORMAL) exp_q.push_back('{data: exp_d, exc: 1'b0});
         else flush = 1'b1;
         hold_data = exp_d;
         @(negedge clk);
         check_bit("rsp_valid_resp", rsp_valid, kind == K_NORMAL);
         check_bit("stall_resp", stall, 1'b0);
         tick();
         flush = 1'b0;
      end else begin
         @(negedge clk);
         check_bit("stall_after_drop", stall, 1'b0);
         check_bit("req_ready_after_drop", req_ready, 1'b1);
         check("rsp_data_after_drop", rsp_data, hold_data);
         tick();
      end
   endtask

   initial begin
      int kind;
      int r;

      reset = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check_bit("reset_req_ready", req_ready, 1'b1);
      check_bit("reset_m_rd_valid", m_rd_valid, 1'b0);
      check("reset_m_rd_addr", m_rd_addr, 32'h0);
      check_bit("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_data", rsp_data, 32'h0);
      check_bit("reset_stall", stall, 1'b0);
      check_bit("reset_exc_adel", exc_adel, 1'b0);
      tick();
      reset = 1'b1;
      tick();

      do_load(32'h0000_0003, 3'd2, 32'h80FF_1234, 0, 0, K_NORMAL);
      do_load(32'h0000_0106, 3'd3, 32'hBEEF_0001, 2, 3, K_NORMAL);
      do_load(32'h0000_0010, 3'd0, 32'h1111_2222, 0, 2, K_DATA);
      do_load(32'h0000_0014, 3'd0, 32'hCAFE_F00D, 0, 0, K_NORMAL);
      do_load(32'h0000_0040, 3'd0, 32'h3333_4444, 2, 0, K_WITHDRAW);
      do_load(32'h0000_0021, 3'd4, 32'h1234_8765, 0, 0, K_NORMAL);
      do_load(32'h0000_0013, 3'd0, 32'h0102_0304, 1, 1, K_NORMAL);
      do_load(32'h0000_0051, 3'd5, 32'hFFFF_FFFF, 0, 1, K_NORMAL);
      do_load(32'h0000_0060, 3'd1, 32'h0000_0080, 1, 0, K_ADDR_HS);
      do_load(32'h0000_0064, 3'd4, 32'h8001_0000, 0, 1, K_RVALID);
      do_load(32'h0000_0068, 3'd2, 32'h0000_7F00, 0, 0, K_RESP);
      idle_cycle(1'b0, 1'b1);
      idle_cycle(1'b1, 1'b0);

      // Reset while a read is outstanding in the data phase, then a late rvalid.
      req_valid = 1'b1;
      req_addr  = 32'h0000_0080;
      req_op    = 3'd0;
      tick();
      req_valid    = 1'b0;
      m_rd_ready   = 1'b1;
      bus_expected = 1'b1;
      exp_bus_addr = 32'h0000_0080;
      tick();
      m_rd_ready   = 1'b0;
      bus_expected = 1'b0;
      reset        = 1'b0;
      @(negedge clk);
      check_bit("stall_before_reset", stall, 1'b1);
      tick();
      reset       = 1'b1;
      hold_data   = 32'h0;
      m_rd_rvalid = 1'b1;
      m_rd_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      check_bit("midreset_m_rd_valid", m_rd_valid, 1'b0);
      check("midreset_m_rd_addr", m_rd_addr, 32'h0);
      check_bit("midreset_rsp_valid", rsp_valid, 1'b0);
      check("midreset_rsp_data", rsp_data, 32'h0);
      check_bit("midreset_stall", stall, 1'b0);
      check_bit("midreset_req_ready", req_ready, 1'b1);
      tick();
      m_rd_rvalid = 1'b0;
      idle_cycle(1'b1, 1'b0);
      do_load(32'h0000_0002, 3'd1, 32'h00A5_0000, 0, 0, K_NORMAL);

      for (int n = 0; n < 300; n++) begin
         r    = $urandom_range(0, 9);
         kind = (r < 5) ? K_NORMAL : r - 4;
         begin
            int rw = $urandom_range(0, 3);
            int vw = $urandom_range(0, 3);
            if (kind == K_WITHDRAW && rw == 0) rw = 1;
            if (kind == K_DATA && vw == 0) vw = 1;
            do_load($urandom, 3'($urandom_range(0, 7)), $urandom, rw, vw, kind);
         end
         if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      repeat (3) tick();
      check("scoreboard_drained", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
